// File: rtl/aduna_pkg.sv
// Shared encodings and helpers for the serial chunked adder.
// Build option ADUNA_SUB_EN adds subtract mode; nothing here depends on it.
package aduna_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  typedef enum logic [1:0] {
    S_IDLE = ST_IDLE,
    S_RUN  = ST_RUN,
    S_DONE = ST_DONE
  } state_t;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    while ((1 << r) < v) r++;
    return r;
  endfunction

endpackage

// File: rtl/aduna_serial_if.sv
// start/busy/done bus for aduna_serial; the sub line exists only under ADUNA_SUB_EN.
// No backpressure: the master must hold start until it sees it accepted (busy).
interface aduna_serial_if #(parameter int WIDTH = 16);

  logic             start;
  logic [WIDTH-1:0] x;
  logic [WIDTH-1:0] y;
  logic             c0;
`ifdef ADUNA_SUB_EN
  logic             sub;
`endif
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] s;
  logic             c4;
  logic             ovf;

`ifdef ADUNA_SUB_EN
  modport master (output start, x, y, c0, sub, input busy, done, s, c4, ovf);
  modport slave  (input start, x, y, c0, sub, output busy, done, s, c4, ovf);
`else
  modport master (output start, x, y, c0, input busy, done, s, c4, ovf);
  modport slave  (input start, x, y, c0, output busy, done, s, c4, ovf);
`endif

endinterface

// File: rtl/aduna_digit.sv
// Combinational DIGIT-bit adder slice, zero latency, no handshake.
module aduna_digit #(
  parameter int DIGIT = 4
) (
  input  logic [DIGIT-1:0] a,
  input  logic [DIGIT-1:0] b,
  input  logic             ci,
  output logic [DIGIT-1:0] sum,
  output logic             co
);

  assign {co, sum} = {1'b0, a} + {1'b0, b} + {{DIGIT{1'b0}}, ci};

endmodule

// File: rtl/aduna_serial.sv
// Serial WIDTH-bit adder, DIGIT bits per cycle; done pulses WIDTH/DIGIT cycles after start.
// start ignored while busy; ADUNA_SUB_EN adds a latched sub input (x - y - c0).
module aduna_serial
  import aduna_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic           clk,
  input  logic           rst,
  aduna_serial_if.slave  bus
);

  localparam int N  = WIDTH / DIGIT;
  localparam int CW = (N > 1) ? clog2(N) : 1;
  localparam logic [CW-1:0] LAST = CW'(N - 1);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] xr;
  logic [WIDTH-1:0] yr;
  logic [WIDTH-1:0] s_q;
  logic             carry;
  logic             busy_q;
  logic             done_q;
  logic             c4_q;
  logic             ovf_q;

  logic [WIDTH-1:0] y_in;
  logic             c_in;
  logic [DIGIT-1:0] a;
  logic [DIGIT-1:0] b;
  logic [DIGIT-1:0] sum;
  logic             co;

  // Subtraction is x + ~y + !c0, so the operand is inverted once on entry.
`ifdef ADUNA_SUB_EN
  assign y_in = bus.sub ? ~bus.y  : bus.y;
  assign c_in = bus.sub ? ~bus.c0 : bus.c0;
`else
  assign y_in = bus.y;
  assign c_in = bus.c0;
`endif

  assign a = xr[DIGIT-1:0];
  assign b = yr[DIGIT-1:0];

  aduna_digit #(.DIGIT(DIGIT)) u_digit (
    .a   (a),
    .b   (b),
    .ci  (carry),
    .sum (sum),
    .co  (co)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state  <= S_IDLE;
      cnt    <= '0;
      xr     <= '0;
      yr     <= '0;
      s_q    <= '0;
      carry  <= 1'b0;
      busy_q <= 1'b0;
      done_q <= 1'b0;
      c4_q   <= 1'b0;
      ovf_q  <= 1'b0;
    end else begin
      case (state)
        S_IDLE, S_DONE: begin
          done_q <= 1'b0;
          state  <= S_IDLE;
          if (bus.start) begin
            xr     <= bus.x;
            yr     <= y_in;
            carry  <= c_in;
            s_q    <= '0;
            c4_q   <= 1'b0;
            ovf_q  <= 1'b0;
            cnt    <= '0;
            busy_q <= 1'b1;
            state  <= S_RUN;
          end
        end
        S_RUN: begin
          xr    <= xr >> DIGIT;
          yr    <= yr >> DIGIT;
          carry <= co;
          // Result fills from the top so the last chunk lands at the MSB.
          s_q   <= (s_q >> DIGIT) | (WIDTH'(sum) << (WIDTH - DIGIT));
          cnt   <= cnt + 1'b1;
          if (cnt == LAST) begin
            c4_q   <= co;
            ovf_q  <= (a[DIGIT-1] == b[DIGIT-1]) && (sum[DIGIT-1] != a[DIGIT-1]);
            cnt    <= '0;
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= S_DONE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = busy_q;
  assign bus.done = done_q;
  assign bus.s    = s_q;
  assign bus.c4   = c4_q;
  assign bus.ovf  = ovf_q;

endmodule

// File: tb/tb_aduna_serial.sv
// Bench for aduna_serial: 16/4 main instance plus 8/1 and 8/8 corner instances.
module tb_aduna_serial;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  aduna_serial_if #(.WIDTH(16)) bus16 ();
  aduna_serial_if #(.WIDTH(8))  bus81 ();
  aduna_serial_if #(.WIDTH(8))  bus88 ();

  aduna_serial #(.WIDTH(16), .DIGIT(4)) dut16 (.clk(clk), .rst(rst), .bus(bus16.slave));
  aduna_serial #(.WIDTH(8),  .DIGIT(1)) dut81 (.clk(clk), .rst(rst), .bus(bus81.slave));
  aduna_serial #(.WIDTH(8),  .DIGIT(8)) dut88 (.clk(clk), .rst(rst), .bus(bus88.slave));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [15:0] x;
    logic [15:0] y;
    logic        c0;
    logic [15:0] s;
    logic        c4;
    logic        ovf;
  } vec_t;

  vec_t tbl [6];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Reference: plain integer arithmetic on the whole operands.
  function automatic logic [17:0] model16(input logic [15:0] x, input logic [15:0] y,
                                          input logic c0, input logic sub);
    logic [16:0] full;
    logic [15:0] s;
    logic        ovf;
    if (sub) full = {1'b0, x} + {1'b0, ~y} + 17'(!c0);
    else     full = {1'b0, x} + {1'b0, y}  + 17'(c0);
    s   = full[15:0];
    ovf = sub ? ((x[15] != y[15]) && (s[15] != x[15]))
              : ((x[15] == y[15]) && (s[15] != x[15]));
    return {ovf, full[16], s};
  endfunction

  function automatic logic [8:0] model8(input logic [7:0] x, input logic [7:0] y, input logic c0);
    return {1'b0, x} + {1'b0, y} + 9'(c0);
  endfunction

  task automatic wait16(input bit scr, output int lat, output int bc);
    lat = 0;
    bc  = 0;
    while (bus16.done !== 1'b1 && lat < 64) begin
      if (bus16.busy === 1'b1) bc++;
      if (scr) begin
        bus16.start = 1'($urandom_range(0, 1));
        bus16.x     = 16'($urandom);
        bus16.y     = 16'($urandom);
        bus16.c0    = 1'($urandom);
      end
      tick();
      lat++;
    end
    if (scr) bus16.start = 1'b0;
  endtask

  task automatic do_op(input logic [15:0] x, input logic [15:0] y, input logic c0, input bit scr,
                       output logic [15:0] s, output logic c4, output logic ovf,
                       output int lat, output int bc);
    bus16.x     = x;
    bus16.y     = y;
    bus16.c0    = c0;
    bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0;
    wait16(scr, lat, bc);
    s   = bus16.s;
    c4  = bus16.c4;
    ovf = bus16.ovf;
  endtask

  task automatic op8(input logic [7:0] x, input logic [7:0] y, input logic c0,
                     output int l1, output int l8, output logic [8:0] r1, output logic [8:0] r8);
    bus81.x = x; bus81.y = y; bus81.c0 = c0; bus81.start = 1'b1;
    bus88.x = x; bus88.y = y; bus88.c0 = c0; bus88.start = 1'b1;
    tick();
    bus81.start = 1'b0;
    bus88.start = 1'b0;
    l1 = -1; l8 = -1; r1 = '0; r8 = '0;
    for (int i = 1; i <= 20 && (l1 < 0 || l8 < 0); i++) begin
      tick();
      if (l1 < 0 && bus81.done === 1'b1) begin l1 = i; r1 = {bus81.c4, bus81.s}; end
      if (l8 < 0 && bus88.done === 1'b1) begin l8 = i; r8 = {bus88.c4, bus88.s}; end
    end
    tick();
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, time %0t required below 500000", $time);
    $fatal(1);
  end

  initial begin
    logic [15:0] s;
    logic        c4, ovf, sb;
    logic [17:0] exp;
    logic [8:0]  r1, r8, e8;
    int          lat, bc, l1, l8, seen;

    tbl[0] = '{16'h0009, 16'h000B, 1'b0, 16'h0014, 1'b0, 1'b0};
    tbl[1] = '{16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0};
    tbl[2] = '{16'h7FFF, 16'h0001, 1'b0, 16'h8000, 1'b0, 1'b1};
    tbl[3] = '{16'h8000, 16'h8000, 1'b0, 16'h0000, 1'b1, 1'b1};
    tbl[4] = '{16'h1234, 16'h1111, 1'b1, 16'h2346, 1'b0, 1'b0};
    tbl[5] = '{16'hFFFF, 16'hFFFF, 1'b1, 16'hFFFF, 1'b1, 1'b0};

    bus16.start = 0; bus16.x = 0; bus16.y = 0; bus16.c0 = 0;
    bus81.start = 0; bus81.x = 0; bus81.y = 0; bus81.c0 = 0;
    bus88.start = 0; bus88.x = 0; bus88.y = 0; bus88.c0 = 0;
`ifdef ADUNA_SUB_EN
    bus16.sub = 0; bus81.sub = 0; bus88.sub = 0;
`endif
    sb = 1'b0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", bus16.busy, 0);
    check("rst_done", bus16.done, 0);
    check("rst_s",    bus16.s,    0);
    check("rst_c4",   bus16.c4,   0);
    check("rst_ovf",  bus16.ovf,  0);
    @(negedge clk) rst = 1'b0;
    tick();

    for (int i = 0; i < 6; i++) begin
      do_op(tbl[i].x, tbl[i].y, tbl[i].c0, 1'b0, s, c4, ovf, lat, bc);
      check($sformatf("tbl%0d_s", i),   s,   tbl[i].s);
      check($sformatf("tbl%0d_c4", i),  c4,  tbl[i].c4);
      check($sformatf("tbl%0d_ovf", i), ovf, tbl[i].ovf);
      check($sformatf("tbl%0d_lat", i), lat, 4);
      check($sformatf("tbl%0d_busy_cycles", i), bc, 4);
      check($sformatf("tbl%0d_busy_at_done", i), bus16.busy, 0);
      tick();
      check($sformatf("tbl%0d_done_pulse", i), bus16.done, 0);
      check($sformatf("tbl%0d_s_held", i), bus16.s, tbl[i].s);
    end

    // Operands changed and start held during RUN, then re-accepted in the DONE cycle.
    bus16.x = 16'h0009; bus16.y = 16'h000B; bus16.c0 = 1'b0; bus16.start = 1'b1;
    tick();
    bus16.x = 16'h1234; bus16.y = 16'h1111;
    wait16(1'b0, lat, bc);
    check("b2b_first_s", bus16.s, 16'h0014);
    check("b2b_first_lat", lat, 4);
    tick();
    bus16.start = 1'b0;
    check("b2b_done_drop", bus16.done, 0);
    check("b2b_rearm_busy", bus16.busy, 1);
    wait16(1'b0, lat, bc);
    check("b2b_second_s", bus16.s, 16'h2345);
    check("b2b_second_lat", lat, 4);
    tick();

    // Asynchronous abort in the second RUN cycle.
    bus16.x = 16'h0009; bus16.y = 16'h000B; bus16.c0 = 1'b0; bus16.start = 1'b1;
    tick();
    bus16.start = 1'b0;
    tick();
    #2 rst = 1'b1;
    #1;
    check("abort_busy", bus16.busy, 0);
    check("abort_done", bus16.done, 0);
    check("abort_s",    bus16.s,    0);
    check("abort_c4",   bus16.c4,   0);
    @(negedge clk) rst = 1'b0;
    seen = 0;
    repeat (8) begin
      tick();
      if (bus16.done === 1'b1) seen++;
    end
    check("abort_no_done", seen, 0);
    do_op(16'h00FF, 16'h0001, 1'b0, 1'b0, s, c4, ovf, lat, bc);
    check("after_abort_s", s, 16'h0100);
    check("after_abort_lat", lat, 4);
    tick();

`ifdef ADUNA_SUB_EN
    bus16.sub = 1'b1;
    do_op(16'h0005, 16'h0007, 1'b0, 1'b0, s, c4, ovf, lat, bc);
    check("sub1_s", s, 16'hFFFE);
    check("sub1_c4", c4, 0);
    check("sub1_ovf", ovf, 0);
    tick();
    do_op(16'h8000, 16'h0001, 1'b0, 1'b0, s, c4, ovf, lat, bc);
    check("sub2_s", s, 16'h7FFF);
    check("sub2_c4", c4, 1);
    check("sub2_ovf", ovf, 1);
    tick();
    bus16.sub = 1'b0;
`endif

    for (int i = 0; i < 40; i++) begin
      logic [15:0] rx, ry;
      logic        rc;
      rx = 16'($urandom);
      ry = 16'($urandom);
      rc = 1'($urandom);
`ifdef ADUNA_SUB_EN
      sb = 1'($urandom);
      bus16.sub = sb;
`endif
      exp = model16(rx, ry, rc, sb);
      do_op(rx, ry, rc, 1'($urandom), s, c4, ovf, lat, bc);
      check($sformatf("rnd%0d_s", i),   s,   exp[15:0]);
      check($sformatf("rnd%0d_c4", i),  c4,  exp[16]);
      check($sformatf("rnd%0d_ovf", i), ovf, exp[17]);
      check($sformatf("rnd%0d_lat", i), lat, 4);
      tick();
    end

    op8(8'hFF, 8'h00, 1'b1, l1, l8, r1, r8);
    check("d1_lat", l1, 8);
    check("d8_lat", l8, 1);
    check("d1_res", r1, 9'h100);
    check("d8_res", r8, 9'h100);
    for (int i = 0; i < 10; i++) begin
      logic [7:0] rx, ry;
      logic       rc;
      rx = 8'($urandom);
      ry = 8'($urandom);
      rc = 1'($urandom);
      e8 = model8(rx, ry, rc);
      op8(rx, ry, rc, l1, l8, r1, r8);
      check($sformatf("d1_rnd%0d", i), r1, e8);
      check($sformatf("d8_rnd%0d", i), r8, e8);
      check($sformatf("d1_rnd%0d_lat", i), l1, 8);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
